// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match sequencer: serve, rally, scoring, game over
// Optional PONG_AUTOSERVE_EN: serve after SERVE_FRAMES frame ticks instead of on a start press.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_reset,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  localparam logic [3:0] WIN_N = 4'(WIN_SCORE);

  state_t     state, state_nxt;
  logic       start_prev;
  logic       start_rise;
  logic       serve_done;
  logic [3:0] score_left_nxt, score_right_nxt;
  logic       serve_dir_nxt, winner_nxt;

  assign start_rise = start_btn & ~start_prev;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

`ifdef PONG_AUTOSERVE_EN
  localparam logic [7:0] SERVE_N = 8'(SERVE_FRAMES);
  logic [7:0] serve_cnt;

  // Counter sits at zero outside SERVE, so every SERVE entry starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      serve_cnt <= 8'd0;
    else if (state != S_SERVE)
      serve_cnt <= 8'd0;
    else if (frame_tick)
      serve_cnt <= serve_cnt + 8'd1;
  end

  assign serve_done = frame_tick && (serve_cnt + 8'd1 == SERVE_N);
`else
  logic unused_serve;
  assign unused_serve = &{1'b0, frame_tick, 8'(SERVE_FRAMES)};
  assign serve_done   = start_rise;
`endif

  always_comb begin
    state_nxt       = state;
    score_left_nxt  = score_left;
    score_right_nxt = score_right;
    serve_dir_nxt   = serve_dir;
    winner_nxt      = winner;
    case (state)
      S_IDLE: if (start_rise) begin
        score_left_nxt  = 4'd0;
        score_right_nxt = 4'd0;
        serve_dir_nxt   = 1'b1;
        state_nxt       = S_SERVE;
      end
      S_SERVE: if (serve_done) state_nxt = S_PLAY;
      S_PLAY: begin
        // Simultaneous misses replay the point without scoring.
        if (miss_left && miss_right) begin
          state_nxt = S_POINT;
        end else if (miss_left) begin
          score_right_nxt = sat_inc(score_right);
          serve_dir_nxt   = 1'b0;
          state_nxt       = S_POINT;
        end else if (miss_right) begin
          score_left_nxt = sat_inc(score_left);
          serve_dir_nxt  = 1'b1;
          state_nxt      = S_POINT;
        end
      end
      S_POINT: begin
        if (score_left == WIN_N) begin
          winner_nxt = 1'b0;
          state_nxt  = S_OVER;
        end else if (score_right == WIN_N) begin
          winner_nxt = 1'b1;
          state_nxt  = S_OVER;
        end else begin
          state_nxt = S_SERVE;
        end
      end
      S_OVER: if (start_rise) begin
        score_left_nxt  = 4'd0;
        score_right_nxt = 4'd0;
        state_nxt       = S_SERVE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ball controls and game_over are registered from the next state so they track state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      start_prev  <= 1'b0;
      ball_reset  <= 1'b1;
      ball_run    <= 1'b0;
      serve_dir   <= 1'b0;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_prev  <= start_btn;
      ball_reset  <= (state_nxt != S_PLAY);
      ball_run    <= (state_nxt == S_PLAY);
      serve_dir   <= serve_dir_nxt;
      score_left  <= score_left_nxt;
      score_right <= score_right_nxt;
      game_over   <= (state_nxt == S_OVER);
      winner      <= winner_nxt;
    end
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 9: points that win a game; legal range 1..15.
REQ-002 Parameter SERVE_FRAMES, default 60: frame ticks of serve delay; legal range 1..255; used only with PONG_AUTOSERVE_EN.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_tick  input  1  one-cycle pulse per video frame.
REQ-006 start_btn  input  1  start/serve button, already synchronised to clk; level input.
REQ-007 miss_left  input  1  one-cycle pulse: ball passed the left edge, so the left player conceded.
REQ-008 miss_right  input  1  one-cycle pulse: ball passed the right edge, so the right player conceded.
REQ-009 ball_reset  output  1  high: ball datapath holds the ball at centre.
REQ-010 ball_run  output  1  high: ball datapath advances the ball.
REQ-011 serve_dir  output  1  initial ball direction; 0 = toward left, 1 = toward right.
REQ-012 score_left, score_right  output  4 each  current scores.
REQ-013 game_over  output  1  high while in OVER.
REQ-014 winner  output  1  0 = left won, 1 = right won; valid while game_over is high.

Function
REQ-015 FSM states: IDLE, SERVE, PLAY, POINT, OVER; all outputs are registered.
REQ-016 start_btn rising edge (start_rise) = registered previous value 0 and current value 1; only start_rise acts, never the level.
REQ-017 IDLE: ball_reset=1, ball_run=0; on start_rise, clear both scores, set serve_dir=1 and go to SERVE.
REQ-018 SERVE: ball_reset=1, ball_run=0; the exit condition is set by REQ-034/REQ-035; on exit go to PLAY.
REQ-019 PLAY: ball_reset=0, ball_run=1; miss_left only: score_right+1, serve_dir=0, go to POINT.
REQ-020 PLAY, miss_right only: score_left+1, serve_dir=1, go to POINT.
REQ-021 PLAY, miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, go to POINT (replay).
REQ-022 miss_left/miss_right are ignored in every state except PLAY.
REQ-023 POINT lasts exactly one cycle with ball_reset=1 and ball_run=0.
REQ-024 POINT exit: if either score equals WIN_SCORE, go to OVER and set winner to that side; otherwise go to SERVE.
REQ-025 Scores saturate at 15 and never wrap.
REQ-026 OVER: game_over=1, ball_reset=1, ball_run=0; scores hold; on start_rise, clear both scores, clear game_over, keep serve_dir, go to SERVE.
REQ-027 Latency: a miss sampled at edge N updates the score and enters POINT at N; the FSM is in SERVE or OVER at edge N+1.
REQ-028 ball_reset and ball_run are never both 1 at the same time.

Reset
REQ-029 reset high immediately and asynchronously forces state IDLE, regardless of the current state.
REQ-030 Reset values: ball_reset=1, ball_run=0, serve_dir=0, scores=0, game_over=0, winner=0, serve counter=0, start_btn edge register=0.
REQ-031 Reset release: the first edge-detected start_btn is the first 0->1 transition sampled after release.
REQ-032 Reset asserted during PLAY discards any miss pulse in the same cycle.

Configuration
REQ-033 Macro PONG_AUTOSERVE_EN selects the SERVE exit condition.
REQ-034 Defined: an 8-bit counter clears on SERVE entry and counts frame_tick pulses only in SERVE; exit when it reaches SERVE_FRAMES; start_btn is ignored in SERVE.
REQ-035 Undefined: SERVE exits on start_rise; frame_tick is ignored and no counter is synthesised.

Verification
REQ-036 Reset, then start_btn 0->1 -> SERVE, scores 0/0, serve_dir=1, ball_reset=1.
REQ-037 PLAY, single-cycle miss_right -> next edge score_left=1, serve_dir=1, POINT; following edge SERVE.
REQ-038 PLAY, miss_left and miss_right together -> scores unchanged, POINT then SERVE, serve_dir unchanged.
REQ-039 WIN_SCORE=3, three miss_left pulses -> score_right=3, OVER, game_over=1, winner=1; further misses ignored; start_rise -> scores 0/0, SERVE.
REQ-040 PONG_AUTOSERVE_EN with SERVE_FRAMES=4 -> PLAY entered on the edge after the 4th frame_tick; held start_btn has no effect. Undefined -> start_rise required; a held level does not advance.
REQ-041 reset pulse mid-PLAY, asynchronous to clk -> outputs take reset values immediately, before the next clk edge.
